// File: rtl/dbus_xbar.sv
// dbus_xbar: NMASTERS x NTARGETS data-bus crossbar with mask/base decode, per-target round-robin
// arbitration and a registered one-cycle read-response route. Define DBUS_XBAR_DECERR_EN for decode-error responses.
module dbus_xbar #(
  parameter int NMASTERS = 4,
  parameter int NTARGETS = 4,
  parameter logic [32*NTARGETS-1:0] TGT_BASE = {32'h40001000, 32'h40000000, 32'h20000000, 32'h10000000},
  parameter logic [32*NTARGETS-1:0] TGT_MASK = {32'hFFFFF000, 32'hFFFFF000, 32'hFFFF0000, 32'hFFFFC000}
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [NMASTERS-1:0]      m_re_i,
  input  logic [NMASTERS-1:0]      m_we_i,
  input  logic [32*NMASTERS-1:0]   m_addr_i,
  input  logic [32*NMASTERS-1:0]   m_wdata_i,
  input  logic [4*NMASTERS-1:0]    m_wstrb_i,
  output logic [32*NMASTERS-1:0]   m_rdata_o,
  output logic [NMASTERS-1:0]      m_stall_o,
  output logic [NMASTERS-1:0]      m_err_o,
  output logic [NTARGETS-1:0]      t_re_o,
  output logic [NTARGETS-1:0]      t_we_o,
  output logic [32*NTARGETS-1:0]   t_addr_o,
  output logic [32*NTARGETS-1:0]   t_wdata_o,
  output logic [4*NTARGETS-1:0]    t_wstrb_o,
  input  logic [32*NTARGETS-1:0]   t_rdata_i,
  input  logic [NTARGETS-1:0]      t_stall_i
);

  localparam int MW = (NMASTERS > 1) ? $clog2(NMASTERS) : 1;
  localparam int TW = (NTARGETS > 1) ? $clog2(NTARGETS) : 1;
  localparam logic [MW-1:0] LAST_M = MW'(NMASTERS - 1);

  logic [NMASTERS-1:0] req;
  logic [NMASTERS-1:0] rd;
  logic [NMASTERS-1:0] routed;
  logic [NMASTERS-1:0] acc;
  logic [TW-1:0]       tsel [NMASTERS];
  logic [MW-1:0]       rr [NTARGETS];
  logic [NTARGETS-1:0] gnt;
  logic [NTARGETS-1:0] tacc;
  logic [MW-1:0]       gidx [NTARGETS];
  logic [NMASTERS-1:0] rvalid;
  logic [TW-1:0]       rtgt [NMASTERS];
`ifdef DBUS_XBAR_DECERR_EN
  logic [NMASTERS-1:0] mapped;
  logic [NMASTERS-1:0] err_acc;
  logic [NMASTERS-1:0] evalid;
  logic [NMASTERS-1:0] err_q;
`endif

  // Decode scans high-to-low so the lowest matching target wins; a miss falls back to the last target.
  always_comb begin
    for (int i = 0; i < NMASTERS; i++) begin
      req[i]  = m_re_i[i] | m_we_i[i];
      rd[i]   = m_re_i[i] & ~m_we_i[i];
      tsel[i] = TW'(NTARGETS - 1);
`ifdef DBUS_XBAR_DECERR_EN
      mapped[i] = 1'b0;
`endif
      for (int j = NTARGETS - 1; j >= 0; j--) begin
        if ((m_addr_i[32*i +: 32] & TGT_MASK[32*j +: 32]) == TGT_BASE[32*j +: 32]) begin
          tsel[i] = TW'(j);
`ifdef DBUS_XBAR_DECERR_EN
          mapped[i] = 1'b1;
`endif
        end
      end
`ifdef DBUS_XBAR_DECERR_EN
      routed[i]  = req[i] & mapped[i];
      err_acc[i] = rst_ni & req[i] & ~mapped[i];
`else
      routed[i]  = req[i];
`endif
    end
  end

  // Round-robin: first routed requester at or after rr[j], wrapping; nothing is granted during reset.
  always_comb begin
    int m;
    m = 0;
    for (int j = 0; j < NTARGETS; j++) begin
      gnt[j]  = 1'b0;
      gidx[j] = '0;
      for (int k = 0; k < NMASTERS; k++) begin
        m = int'(rr[j]) + k;
        if (m >= NMASTERS) m = m - NMASTERS;
        if (!gnt[j] && routed[m] && (int'(tsel[m]) == j)) begin
          gnt[j]  = 1'b1;
          gidx[j] = MW'(m);
        end
      end
      gnt[j]  = gnt[j] & rst_ni;
      tacc[j] = gnt[j] & ~t_stall_i[j];
    end
  end

  always_comb begin
    t_re_o    = '0;
    t_we_o    = '0;
    t_addr_o  = '0;
    t_wdata_o = '0;
    t_wstrb_o = '0;
    acc       = '0;
    for (int j = 0; j < NTARGETS; j++) begin
      if (gnt[j]) begin
        t_re_o[j]             = rd[gidx[j]];
        t_we_o[j]             = m_we_i[gidx[j]];
        t_addr_o[32*j +: 32]  = m_addr_i[32*gidx[j] +: 32];
        t_wdata_o[32*j +: 32] = m_wdata_i[32*gidx[j] +: 32];
        t_wstrb_o[4*j +: 4]   = m_wstrb_i[4*gidx[j] +: 4];
        if (tacc[j]) acc[gidx[j]] = 1'b1;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NMASTERS; i++) begin
`ifdef DBUS_XBAR_DECERR_EN
      m_stall_o[i] = rst_ni & req[i] & ~acc[i] & ~err_acc[i];
`else
      m_stall_o[i] = rst_ni & req[i] & ~acc[i];
`endif
    end
  end

  // Pointers advance past the accepted grantee; the response route remembers which target to read back from.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int j = 0; j < NTARGETS; j++) rr[j] <= '0;
      for (int i = 0; i < NMASTERS; i++) rtgt[i] <= '0;
      rvalid <= '0;
    end else begin
      for (int j = 0; j < NTARGETS; j++) begin
        if (tacc[j]) rr[j] <= (gidx[j] == LAST_M) ? '0 : gidx[j] + 1'b1;
      end
      for (int i = 0; i < NMASTERS; i++) begin
        rvalid[i] <= acc[i] & rd[i];
        if (acc[i]) rtgt[i] <= tsel[i];
      end
    end
  end

`ifdef DBUS_XBAR_DECERR_EN
  // Unmapped accesses complete locally: reads get a poison word next cycle, the error flag sticks until reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      evalid <= '0;
      err_q  <= '0;
    end else begin
      evalid <= err_acc & rd;
      err_q  <= err_q | err_acc;
    end
  end

  assign m_err_o = err_q;
`else
  assign m_err_o = '0;
`endif

  always_comb begin
    for (int i = 0; i < NMASTERS; i++) begin
      m_rdata_o[32*i +: 32] = '0;
      if (rvalid[i]) begin
        m_rdata_o[32*i +: 32] = t_rdata_i[32*rtgt[i] +: 32];
      end
`ifdef DBUS_XBAR_DECERR_EN
      else if (evalid[i]) begin
        m_rdata_o[32*i +: 32] = 32'hDEADBEEF;
      end
`endif
    end
  end

endmodule

// File: tb/tb_dbus_xbar.sv
// tb_dbus_xbar: randomized and directed stimulus for dbus_xbar, checked by a queue scoreboard
// fed from a behavioural crossbar model; honours DBUS_XBAR_DECERR_EN when defined.
module tb_dbus_xbar;

  localparam int NM = 4;
  localparam int NT = 4;
  localparam logic [32*NT-1:0] BASE = {32'h40001000, 32'h40000000, 32'h20000000, 32'h10000000};
  localparam logic [32*NT-1:0] MASK = {32'hFFFFF000, 32'hFFFFF000, 32'hFFFF0000, 32'hFFFFC000};
`ifdef DBUS_XBAR_DECERR_EN
  localparam bit DECERR = 1'b1;
`else
  localparam bit DECERR = 1'b0;
`endif

  logic              clk_i = 1'b0;
  logic              rst_ni = 1'b0;
  logic [NM-1:0]     m_re_i, m_we_i;
  logic [32*NM-1:0]  m_addr_i, m_wdata_i;
  logic [4*NM-1:0]   m_wstrb_i;
  logic [32*NM-1:0]  m_rdata_o;
  logic [NM-1:0]     m_stall_o, m_err_o;
  logic [NT-1:0]     t_re_o, t_we_o;
  logic [32*NT-1:0]  t_addr_o, t_wdata_o;
  logic [4*NT-1:0]   t_wstrb_o;
  logic [32*NT-1:0]  t_rdata_i;
  logic [NT-1:0]     t_stall_i;

  dbus_xbar #(.NMASTERS(NM), .NTARGETS(NT), .TGT_BASE(BASE), .TGT_MASK(MASK)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .m_re_i(m_re_i), .m_we_i(m_we_i), .m_addr_i(m_addr_i), .m_wdata_i(m_wdata_i),
    .m_wstrb_i(m_wstrb_i), .m_rdata_o(m_rdata_o), .m_stall_o(m_stall_o), .m_err_o(m_err_o),
    .t_re_o(t_re_o), .t_we_o(t_we_o), .t_addr_o(t_addr_o), .t_wdata_o(t_wdata_o),
    .t_wstrb_o(t_wstrb_o), .t_rdata_i(t_rdata_i), .t_stall_i(t_stall_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [NM-1:0]    stall;
    logic [NM-1:0]    err;
    logic [32*NM-1:0] rdata;
    logic [NT-1:0]    t_re;
    logic [NT-1:0]    t_we;
    logic [32*NT-1:0] t_addr;
    logic [32*NT-1:0] t_wdata;
    logic [4*NT-1:0]  t_wstrb;
  } rec_t;

  rec_t sb [$];
  int tests = 0;
  int fails = 0;

  logic [NM-1:0]    s_re, s_we;
  logic [NT-1:0]    s_tstall;
  logic [31:0]      s_addr [NM];
  logic [31:0]      s_wdata [NM];
  logic [3:0]       s_wstrb [NM];
  logic [31:0]      tcur [NT];
  logic [31:0]      tnext [NT];
  int               rr_m [NT];
  logic [NM-1:0]    err_m;
  logic [32*NM-1:0] pend;

  task automatic check_output(input string name, input logic [511:0] act, input logic [511:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic int decode(input logic [31:0] a);
    for (int j = 0; j < NT; j++)
      if ((a & MASK[32*j +: 32]) == BASE[32*j +: 32]) return j;
    return -1;
  endfunction

  function automatic logic [31:0] rand_addr();
    int k;
    int j;
    k = $urandom_range(0, 2*NT);
    if (k == 2*NT) return 32'h3000_0000 | (32'($urandom_range(0, 255)) << 2);
    j = k % NT;
    return (BASE[32*j +: 32] | ($urandom & ~MASK[32*j +: 32])) & 32'hFFFF_FFFC;
  endfunction

  task automatic set_idle();
    s_re = '0;
    s_we = '0;
    s_tstall = '0;
    for (int i = 0; i < NM; i++) begin
      s_addr[i]  = '0;
      s_wdata[i] = $urandom;
      s_wstrb[i] = 4'hF;
    end
    for (int j = 0; j < NT; j++) tnext[j] = $urandom;
  endtask

  task automatic randomize_inputs();
    int r;
    for (int i = 0; i < NM; i++) begin
      r = $urandom_range(0, 3);
      s_re[i]    = (r == 1) || (r == 3);
      s_we[i]    = (r == 2);
      s_addr[i]  = rand_addr();
      s_wdata[i] = $urandom;
      s_wstrb[i] = 4'($urandom_range(0, 15));
    end
    for (int j = 0; j < NT; j++) begin
      s_tstall[j] = ($urandom_range(0, 3) == 0);
      tnext[j]    = $urandom;
    end
  endtask

  task automatic drive_inputs();
    m_re_i = s_re;
    m_we_i = s_we;
    for (int i = 0; i < NM; i++) begin
      m_addr_i[32*i +: 32]  = s_addr[i];
      m_wdata_i[32*i +: 32] = s_wdata[i];
      m_wstrb_i[4*i +: 4]   = s_wstrb[i];
    end
    for (int j = 0; j < NT; j++) t_rdata_i[32*j +: 32] = tcur[j];
    t_stall_i = s_tstall;
  endtask

  // Drive one cycle and predict it: the winner per target is the requester closest after the pointer.
  task automatic apply_stimulus();
    rec_t r;
    int tg [NM];
    int w, best, d;
    logic [NM-1:0] req, acc;
    logic [32*NM-1:0] nxt;
    drive_inputs();
    r = '0;
    req = s_re | s_we;
    acc = '0;
    nxt = '0;
    for (int i = 0; i < NM; i++) begin
      tg[i] = decode(s_addr[i]);
      if (tg[i] < 0 && !DECERR) tg[i] = NT - 1;
      if (tg[i] < 0) acc[i] = req[i];
    end
    for (int j = 0; j < NT; j++) begin
      w = -1;
      best = NM;
      for (int i = 0; i < NM; i++) begin
        if (req[i] && tg[i] == j) begin
          d = (i - rr_m[j] + NM) % NM;
          if (d < best) begin best = d; w = i; end
        end
      end
      if (w >= 0) begin
        r.t_re[j]              = s_re[w] & ~s_we[w];
        r.t_we[j]              = s_we[w];
        r.t_addr[32*j +: 32]   = s_addr[w];
        r.t_wdata[32*j +: 32]  = s_wdata[w];
        r.t_wstrb[4*j +: 4]    = s_wstrb[w];
        if (!s_tstall[j]) begin
          acc[w] = 1'b1;
          rr_m[j] = (w + 1) % NM;
        end
      end
    end
    for (int i = 0; i < NM; i++) begin
      r.stall[i] = req[i] & ~acc[i];
      if (acc[i] && s_re[i] && !s_we[i])
        nxt[32*i +: 32] = (tg[i] < 0) ? 32'hDEADBEEF : tnext[tg[i]];
    end
    r.rdata = pend;
    r.err = err_m;
    for (int i = 0; i < NM; i++) if (req[i] && tg[i] < 0) err_m[i] = 1'b1;
    pend = nxt;
    for (int j = 0; j < NT; j++) tcur[j] = tnext[j];
    sb.push_back(r);
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
    apply_stimulus();
  endtask

  task automatic reset_model();
    for (int j = 0; j < NT; j++) begin
      rr_m[j] = 0;
      tcur[j] = '0;
    end
    err_m = '0;
    pend = '0;
  endtask

  always @(negedge clk_i) begin
    rec_t r;
    if (sb.size() > 0) begin
      r = sb.pop_front();
      check_output("m_stall", m_stall_o, r.stall);
      check_output("m_rdata", m_rdata_o, r.rdata);
      check_output("m_err", m_err_o, r.err);
      check_output("t_re", t_re_o, r.t_re);
      check_output("t_we", t_we_o, r.t_we);
      check_output("t_addr", t_addr_o, r.t_addr);
      check_output("t_wdata", t_wdata_o, r.t_wdata);
      check_output("t_wstrb", t_wstrb_o, r.t_wstrb);
    end
  end

  initial begin
    logic [NM-1:0] exp_stall;
    reset_model();
    randomize_inputs();
    drive_inputs();
    #3;
    check_output("reset_stall", m_stall_o, 0);
    check_output("reset_t_re", t_re_o, 0);
    check_output("reset_t_we", t_we_o, 0);
    check_output("reset_rdata", m_rdata_o, 0);
    check_output("reset_err", m_err_o, 0);
    set_idle();
    drive_inputs();
    @(posedge clk_i);
    #1 rst_ni = 1'b1;

    set_idle();
    s_re[0] = 1'b1;
    s_addr[0] = 32'h1000_0004;
    tnext[0] = 32'h1234_5678;
    step();
    #1;
    check_output("single_t_re", t_re_o[0], 1);
    check_output("single_stall", m_stall_o[0], 0);
    set_idle();
    step();
    #1 check_output("single_rdata", m_rdata_o[31:0], 32'h1234_5678);
    set_idle();
    step();
    #1 check_output("single_rdata_clr", m_rdata_o[31:0], 0);

    set_idle();
    s_we[0] = 1'b1;
    s_addr[0] = 32'h1000_0000;
    s_re[1] = 1'b1;
    s_addr[1] = 32'h4000_0000;
    step();
    #1 check_output("parallel_stall", m_stall_o, 0);

    set_idle();
    s_re[2] = 1'b1;
    s_addr[2] = 32'h4000_0010;
    s_tstall[2] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      #1 check_output("tstall_hold", m_stall_o[2], 1);
    end
    s_tstall = '0;
    step();
    #1 check_output("tstall_release", m_stall_o[2], 0);

    set_idle();
    s_re[3] = 1'b1;
    s_addr[3] = 32'h3000_0000;
    tnext[NT-1] = 32'h5A5A_0003;
    step();
`ifdef DBUS_XBAR_DECERR_EN
    #1 check_output("unmapped_stall", m_stall_o[3], 0);
    set_idle();
    step();
    #1;
    check_output("unmapped_rdata", m_rdata_o[127:96], 32'hDEADBEEF);
    check_output("unmapped_err", m_err_o[3], 1);
`else
    #1 check_output("unmapped_t_re", t_re_o[NT-1], 1);
    set_idle();
    step();
    #1 check_output("unmapped_rdata", m_rdata_o[127:96], 32'h5A5A_0003);
`endif

    for (int n = 0; n < 400; n++) begin
      randomize_inputs();
      step();
    end

    set_idle();
    s_re[0] = 1'b1;
    s_addr[0] = 32'h1000_0000;
    tnext[0] = 32'hCAFE_F00D;
    step();
    @(posedge clk_i);
    #1 rst_ni = 1'b0;
    t_rdata_i[31:0] = 32'hCAFE_F00D;
    #1;
    check_output("midreset_rdata", m_rdata_o, 0);
    check_output("midreset_stall", m_stall_o, 0);
    check_output("midreset_t_re", t_re_o, 0);
    check_output("midreset_err", m_err_o, 0);
    reset_model();
    set_idle();
    drive_inputs();
    @(posedge clk_i);
    #1 rst_ni = 1'b1;

    set_idle();
    s_we = '1;
    for (int i = 0; i < NM; i++) s_addr[i] = 32'h1000_0000;
    for (int k = 0; k < 5; k++) begin
      step();
      exp_stall = 4'hF & ~(4'b0001 << (k % NM));
      #1 check_output("rr_wrap", m_stall_o, exp_stall);
    end

    set_idle();
    step();
    for (int k = 0; k < 20; k++) begin
      if (sb.size() == 0) break;
      @(negedge clk_i);
    end
    #1 check_output("scoreboard_drain", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
